display_scan_7seg: RTL and testbench



---
 rtl/display_scan_7seg.sv | 135 +++++++++++++
 tb/tb_display_scan_7seg.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/display_scan_7seg.sv
// Four-digit common-anode 7-segment scanner with alarm blink and a steady alert dot on digit 0.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module display_scan_7seg #(
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hexa3,
    input  logic [3:0] hexa2,
    input  logic [3:0] hexa1,
    input  logic [3:0] hexa0,
    input  logic       AlarmaAlerta,
    output logic [3:0] anodo,
    output logic [6:0] segmentos,
    output logic       dp
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    // Active-low hex font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          bph_q, bph_d;
    logic [3:0]    anodo_q, anodo_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_s;
    logic [3:0]    digit_s;
    logic          lz_blank_s;

    // Prescaler, scan select and blink phase next-state.
    always_comb begin
        tick_s = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d  = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
        sel_d  = tick_s ? sel_q + 2'd1 : sel_q;
        bcnt_d = bcnt_q;
        bph_d  = bph_q;
        if (!AlarmaAlerta) begin
            bcnt_d = {BW{1'b0}};
            bph_d  = 1'b0;
        end else if (tick_s) begin
            if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
                bcnt_d = {BW{1'b0}};
                bph_d  = ~bph_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // Digit mux, leading-zero test and output register next-state.
    always_comb begin
        case (sel_q)
            2'd0:    digit_s = hexa0;
            2'd1:    digit_s = hexa1;
            2'd2:    digit_s = hexa2;
            2'd3:    digit_s = hexa3;
            default: digit_s = hexa0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (sel_q)
            2'd3:    lz_blank_s = (hexa3 == 4'h0);
            2'd2:    lz_blank_s = (hexa3 == 4'h0) && (hexa2 == 4'h0);
            2'd1:    lz_blank_s = (hexa3 == 4'h0) && (hexa2 == 4'h0) && (hexa1 == 4'h0);
            default: lz_blank_s = 1'b0;
        endcase
`else
        lz_blank_s = 1'b0;
`endif
        anodo_d = ~(4'b0001 << sel_q);
        seg_d   = lz_blank_s ? 7'h7F : hex_to_seg(digit_s);
        if (AlarmaAlerta && bph_q) begin
            anodo_d = 4'b1111;
            seg_d   = 7'h7F;
        end else begin
            anodo_d = anodo_d;
        end
        dp_d = ~((sel_q == 2'd0) && AlarmaAlerta && !bph_q);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= {CW{1'b0}};
            sel_q   <= 2'd0;
            bcnt_q  <= {BW{1'b0}};
            bph_q   <= 1'b0;
            anodo_q <= 4'b1111;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            bcnt_q  <= bcnt_d;
            bph_q   <= bph_d;
            anodo_q <= anodo_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign anodo     = anodo_q;
    assign segmentos = seg_q;
    assign dp        = dp_q;

endmodule

// File: tb/tb_display_scan_7seg.sv
// Directed bench for display_scan_7seg with TICK_DIV=4, BLINK_TICKS=2.
module tb_display_scan_7seg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] hexa3 = 4'h0, hexa2 = 4'h0, hexa1 = 4'h0, hexa0 = 4'h0;
    logic       AlarmaAlerta = 1'b0;
    logic [3:0] anodo;
    logic [6:0] segmentos;
    logic       dp;

    int errors = 0;
    int checks = 0;

    logic [6:0] font [16];
    logic [3:0] slot_an [4];
    logic [6:0] slot_seg [4];

    display_scan_7seg #(.TICK_DIV(4), .BLINK_TICKS(2)) dut (
        .clk(clk), .reset(reset),
        .hexa3(hexa3), .hexa2(hexa2), .hexa1(hexa1), .hexa0(hexa0),
        .AlarmaAlerta(AlarmaAlerta),
        .anodo(anodo), .segmentos(segmentos), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] an, input logic [6:0] sg, input logic d);
        check({tag, " anodo"}, {4'h0, anodo}, {4'h0, an});
        check({tag, " seg"}, {1'b0, segmentos}, {1'b0, sg});
        check({tag, " dp"}, {7'h0, dp}, {7'h0, d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset state and basic scan with digits 1,2,3,4
        hexa3 = 4'h1; hexa2 = 4'h2; hexa1 = 4'h3; hexa0 = 4'h4;
        do_reset();
        check_out("reset", 4'b1111, 7'h7F, 1'b1);
        slot_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        slot_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                check_out($sformatf("scan s%0d c%0d", s, c), slot_an[s], slot_seg[s], 1'b1);
            end
        end
        step();
        check_out("scan wrap", 4'b1110, 7'h19, 1'b1);

        // Full font on digit 0
        for (int v = 0; v < 16; v++) begin
            hexa0 = 4'(v);
            do_reset();
            step();
            check($sformatf("font %0h", v), {1'b0, segmentos}, {1'b0, font[v]});
        end

        // Live hexa change mid-slot shows one clock later
        hexa0 = 4'h8;
        do_reset();
        step();
        step();
        check_out("hexa hold", 4'b1110, 7'h00, 1'b1);
        hexa0 = 4'hF;
        step();
        check_out("hexa change", 4'b1110, 7'h0E, 1'b1);

        // Alarm from reset: 8 visible, 8 blank, visible again
        hexa0 = 4'h4;
        AlarmaAlerta = 1'b1;
        do_reset();
        for (int e = 1; e <= 17; e++) begin
            step();
            if (e <= 4)
                check_out($sformatf("blink e%0d", e), 4'b1110, 7'h19, 1'b0);
            else if (e <= 8)
                check_out($sformatf("blink e%0d", e), 4'b1101, 7'h30, 1'b1);
            else if (e <= 16)
                check_out($sformatf("blink e%0d", e), 4'b1111, 7'h7F, 1'b1);
            else
                check_out($sformatf("blink e%0d", e), 4'b1110, 7'h19, 1'b0);
        end

        // Alarm drops during blank phase
        do_reset();
        for (int e = 1; e <= 10; e++) step();
        check_out("drop blank", 4'b1111, 7'h7F, 1'b1);
        AlarmaAlerta = 1'b0;
        step();
        step();
        check_out("drop restored", 4'b1011, 7'h24, 1'b1);
        for (int e = 13; e <= 17; e++) step();
        check_out("drop dp", 4'b1110, 7'h19, 1'b1);

        // Reset mid-scan during slot 2
        do_reset();
        for (int e = 1; e <= 9; e++) step();
        check_out("slot2", 4'b1011, 7'h24, 1'b1);
        reset = 1'b1;
        step();
        check_out("mid reset", 4'b1111, 7'h7F, 1'b1);
        reset = 1'b0;
        step();
        check_out("restart", 4'b1110, 7'h19, 1'b1);

        // Leading zeros: hexa = 0,0,5,0
        hexa3 = 4'h0; hexa2 = 4'h0; hexa1 = 4'h5; hexa0 = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
        slot_seg = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
        slot_seg = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif
        do_reset();
        for (int s = 0; s < 4; s++) begin
            step();
            check_out($sformatf("lz s%0d", s), slot_an[s], slot_seg[s], 1'b1);
            step();
            step();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
